// File: rtl/present_pkg.sv
// rtl/present_pkg.sv - shared widths, limits and FSM state type for the PRESENT block feeder
package present_pkg;

    localparam int PRESENT_BLOCK_W = 16;
    localparam int PRESENT_KEY_W   = 20;
    localparam int SETTLE_MAX      = 15;

    typedef enum logic [1:0] {
        COLLECT_HI = 2'd0,
        COLLECT_LO = 2'd1,
        SETTLE     = 2'd2
    } feed_state_t;

endpackage

// File: rtl/present_feeder.sv
// rtl/present_feeder.sv - packs byte stream into blocks for present_encipher and captures its ciphertext
module present_feeder
    import present_pkg::*;
#(
    parameter int SETTLE_CYCLES = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       key_load,
    input  logic [PRESENT_KEY_W-1:0]   key_in,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [7:0]                 in_byte,
    output logic [PRESENT_KEY_W-1:0]   key_out,
    output logic                       key_valid,
    output logic [PRESENT_BLOCK_W-1:0] ptext,
    input  logic [PRESENT_BLOCK_W-1:0] ctext,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [PRESENT_BLOCK_W-1:0] out_block
);

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

    feed_state_t state, state_next;
    logic [3:0]  settle_cnt;
    logic [7:0]  hi_byte;
    logic        byte_fire;
    logic        slot_free;
    logic        key_take;
    logic        hi_take;
    logic        load_ptext;
    logic        sample;

    assign in_ready  = key_valid && (state == COLLECT_HI || state == COLLECT_LO);
    assign byte_fire = in_valid && in_ready;
    assign slot_free = !out_valid || out_ready;

    // Key changes only between blocks, so every block is enciphered under a single key.
    always_comb begin
        state_next = state;
        key_take   = 1'b0;
        hi_take    = 1'b0;
        load_ptext = 1'b0;
        sample     = 1'b0;
        case (state)
            COLLECT_HI: begin
                key_take = key_load;
                if (byte_fire) begin
                    hi_take    = 1'b1;
                    state_next = COLLECT_LO;
                end
            end
            COLLECT_LO: begin
                if (byte_fire) begin
                    load_ptext = 1'b1;
                    state_next = SETTLE;
                end
            end
            SETTLE: begin
                if (settle_cnt == SETTLE_LAST && slot_free) begin
                    sample     = 1'b1;
                    state_next = COLLECT_HI;
                end
            end
            default: state_next = COLLECT_HI;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= COLLECT_HI;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_out    <= '0;
            key_valid  <= 1'b0;
            hi_byte    <= '0;
            ptext      <= '0;
            settle_cnt <= '0;
            out_block  <= '0;
            out_valid  <= 1'b0;
        end else begin
            if (key_take) begin
                key_out   <= key_in;
                key_valid <= 1'b1;
            end
            if (hi_take) begin
                hi_byte <= in_byte;
            end
            // Counter saturates at its last value while the output slot is busy.
            if (load_ptext) begin
                ptext      <= {hi_byte, in_byte};
                settle_cnt <= '0;
            end else if (state == SETTLE && settle_cnt != SETTLE_LAST) begin
                settle_cnt <= settle_cnt + 4'd1;
            end
            if (sample) begin
                out_block <= ctext;
                out_valid <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: doc/present_feeder.md
PRESENT_FEEDER -- requirements
Module: present_feeder

Interface
REQ-001 Parameter: SETTLE_CYCLES, default 1, number of cycles (1..15) ptext is held stable before ctext is sampled.
REQ-002 Clock and reset: one clock; reset is asynchronous and active-high.
REQ-003 clk  in  1  sole clock; all state changes on rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 key_load  in  1  single-cycle strobe; captures key_in.
REQ-006 key_in  in  20  master key value.
REQ-007 in_valid  in  1  in_byte is valid.
REQ-008 in_ready  out  1  block accepts in_byte this cycle.
REQ-009 in_byte  in  8  plaintext byte stream, MSB byte first.
REQ-010 key_out  out  20  registered master key; drives present_encipher master_key.
REQ-011 key_valid  out  1  a key has been loaded since reset.
REQ-012 ptext  out  16  registered plaintext block; drives present_encipher ptext.
REQ-013 ctext  in  16  ciphertext returned by present_encipher (combinational).
REQ-014 out_valid  out  1  out_block holds an unconsumed ciphertext.
REQ-015 out_ready  in  1  downstream accepts out_block.
REQ-016 out_block  out  16  registered ciphertext.

Function
REQ-017 FSM states: COLLECT_HI, COLLECT_LO, SETTLE; reset state COLLECT_HI.
REQ-018 in_ready SHALL be 1 only when key_valid=1 and state is COLLECT_HI or COLLECT_LO; combinational from registers only.
REQ-019 Byte transfer occurs on an edge where in_valid=1 and in_ready=1.
REQ-020 COLLECT_HI: transfer stores in_byte as the high byte; next state COLLECT_LO.
REQ-021 COLLECT_LO: transfer loads ptext with {high byte, in_byte} and clears settle counter; next state SETTLE.
REQ-022 SETTLE: counter increments each cycle; ptext and key_out stay unchanged.
REQ-023 Leaving SETTLE occurs at the edge where counter = SETTLE_CYCLES-1 and the output slot is free (out_valid=0 or out_ready=1). At that edge out_block<=ctext, out_valid<=1, next state COLLECT_HI.
REQ-024 If the slot is not free, SETTLE holds with counter saturated; no ctext sample is taken.
REQ-025 Latency: with SETTLE_CYCLES=N and a free slot, out_valid rises N edges after the edge that loads ptext.
REQ-026 out_valid clears on an edge with out_ready=1, unless REQ-023 reloads it on the same edge. A simultaneous handoff plus reload SHALL lose no block.
REQ-027 out_block SHALL be stable while out_valid=1 and out_ready=0.
REQ-028 key_load is honoured only in COLLECT_HI: key_out<=key_in, key_valid<=1. It is ignored in COLLECT_LO and SETTLE, so no block mixes keys.
REQ-029 key_load and a high-byte transfer on the same edge: both are taken, and the new key applies to that block.
REQ-030 Byte collection continues while out_valid=1; at most one block waits in SETTLE.
REQ-031 Counter is 4 bits; it never wraps.

Reset
REQ-032 On rst: state=COLLECT_HI, counter=0, key_out=0, key_valid=0, ptext=0, out_block=0, out_valid=0, high-byte register=0.
REQ-033 Reset mid-block or mid-SETTLE discards the partial or pending block and any undelivered out_block. The loaded key is discarded and must be reloaded.

Structure
REQ-034 Package present_pkg holds: PRESENT_BLOCK_W=16, PRESENT_KEY_W=20, the state enum, and the max SETTLE_CYCLES.
REQ-035 No sub-module inside present_feeder. The parent instantiates present_encipher alongside it and wires ptext/key_out/ctext.

Verification
REQ-036 No key loaded, in_valid=1 held for 10 cycles -> in_ready=0 throughout, and no out_valid.
REQ-037 Bench stub ctext=ptext^16'hA5A5, N=1, key 20'h12345, bytes 8'h3C, 8'hC3 -> ptext=16'h3CC3. One edge later out_valid=1 and out_block=16'h9966.
REQ-038 N=3, out_ready=0, two blocks 16'h0001 and 16'h0002 sent back-to-back -> first block held. Second waits in SETTLE with in_ready=0. Raising out_ready delivers 16'hA5A4, then 16'hA5A7, with none lost.
REQ-039 key_load with 20'hFFFFF in COLLECT_LO -> key_out unchanged. Same strobe in COLLECT_HI with a simultaneous byte -> key_out=20'hFFFFF.
REQ-040 rst asserted asynchronously during SETTLE -> all outputs zero immediately. After reload, the next block completes normally.
REQ-041 Integration with present_encipher: 1000 random keys/blocks -> out_block matches the bench golden model for every block.
